// File: rtl/mem_entry_ctrl_if.sv
// Request/acknowledge memory port shared by the entry controller and the memory.
interface mem_entry_ctrl_if;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_ack;
  logic [15:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/mem_entry_ctrl.sv
// Front-panel entry controller: switch nibbles and enter/back presses drive
// read, write and whole-memory clear transactions on a req/ack memory port.
module mem_entry_ctrl #(
  parameter int unsigned ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [9:0]        sw,
  input  logic              btn_enter,
  input  logic              btn_back,
  mem_entry_ctrl_if.master  mem,
  output logic [1:0]        modeSelect,
  output logic [1:0]        stage,
  output logic [15:0]       inVal,
  output logic              busy
);

  localparam logic [15:0] ADDR_MASK = 16'((32'd1 << ADDR_W) - 32'd1);

  localparam logic [1:0] MODE_CLR  = 2'b00;
  localparam logic [1:0] MODE_RD   = 2'b01;
  localparam logic [1:0] MODE_WR   = 2'b10;
  localparam logic [1:0] MODE_IDLE = 2'b11;

  localparam logic [1:0] ST_BANNER = 2'd0;
  localparam logic [1:0] ST_ENTRY  = 2'd1;
  localparam logic [1:0] ST_MID    = 2'd2;
  localparam logic [1:0] ST_LAST   = 2'd3;

  logic        enter_q, back_q;
  logic [1:0]  mode_q, mode_d;
  logic [1:0]  stage_q, stage_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [15:0] shreg_q, shreg_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] rdata_q, rdata_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic        busy_q, busy_d;
  logic [15:0] inval_q, inval_d;

  logic        enter_p, back_p, last_nib, done;
  logic [15:0] shreg_nx;
  logic        unused_sw;

  assign unused_sw = ^sw[7:4];

  assign enter_p  = btn_enter & ~enter_q;
  assign back_p   = btn_back & ~back_q;
  assign shreg_nx = {shreg_q[11:0], sw[3:0]};
  assign last_nib = (cnt_q == 2'd3);
  assign done     = req_q & mem.mem_ack;

  // State register; button history flops reset high so a held button is not a press.
  always_ff @(posedge clk) begin
    if (rst) begin
      enter_q <= 1'b1;
      back_q  <= 1'b1;
      mode_q  <= MODE_IDLE;
      stage_q <= ST_BANNER;
      cnt_q   <= 2'd0;
      shreg_q <= 16'd0;
      addr_q  <= 16'd0;
      wdata_q <= 16'd0;
      rdata_q <= 16'd0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      inval_q <= 16'd0;
    end else begin
      enter_q <= btn_enter;
      back_q  <= btn_back;
      mode_q  <= mode_d;
      stage_q <= stage_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      req_q   <= req_d;
      we_q    <= we_d;
      busy_q  <= busy_d;
      inval_q <= inval_d;
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    mode_d  = mode_q;
    stage_d = stage_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    req_d   = req_q;
    we_d    = we_q;

    if (stage_q == ST_BANNER && !req_q) mode_d = sw[9:8];

    case (stage_q)
      ST_BANNER: begin
        if (enter_p && !back_p) begin
          case (mode_d)
            MODE_RD, MODE_WR: begin
              stage_d = ST_ENTRY;
              shreg_d = 16'd0;
              cnt_d   = 2'd0;
            end
            MODE_CLR: begin
              stage_d = ST_ENTRY;
              addr_d  = 16'd0;
              wdata_d = 16'd0;
              req_d   = 1'b1;
              we_d    = 1'b1;
            end
            default: ;
          endcase
        end
      end
      ST_ENTRY: begin
        if (mode_q == MODE_CLR) begin
          if (done) begin
            if (addr_q == ADDR_MASK) begin
              req_d   = 1'b0;
              stage_d = ST_BANNER;
            end else begin
              addr_d = addr_q + 16'd1;
            end
          end
        end else if (back_p) begin
          stage_d = ST_BANNER;
          shreg_d = 16'd0;
          cnt_d   = 2'd0;
        end else if (enter_p) begin
          shreg_d = shreg_nx;
          cnt_d   = cnt_q + 2'd1;
          if (last_nib) begin
            addr_d  = shreg_nx & ADDR_MASK;
            shreg_d = 16'd0;
            stage_d = ST_MID;
            if (mode_q == MODE_RD) begin
              req_d = 1'b1;
              we_d  = 1'b0;
            end
          end
        end
      end
      ST_MID: begin
        if (mode_q == MODE_RD) begin
          if (done) begin
            rdata_d = mem.mem_rdata;
            req_d   = 1'b0;
            stage_d = ST_LAST;
          end
        end else if (back_p) begin
          stage_d = ST_BANNER;
          shreg_d = 16'd0;
          cnt_d   = 2'd0;
        end else if (enter_p) begin
          shreg_d = shreg_nx;
          cnt_d   = cnt_q + 2'd1;
          if (last_nib) begin
            wdata_d = shreg_nx;
            shreg_d = 16'd0;
            stage_d = ST_LAST;
            req_d   = 1'b1;
            we_d    = 1'b1;
          end
        end
      end
      default: begin
        // Pending write holds here until ack; once idle, enter or back leaves.
        if (req_q) begin
          if (mem.mem_ack) req_d = 1'b0;
        end else if (enter_p || back_p) begin
          stage_d = ST_BANNER;
          shreg_d = 16'd0;
          cnt_d   = 2'd0;
        end
      end
    endcase

    busy_d = req_d;

    case (stage_d)
      ST_BANNER: inval_d = 16'd0;
      ST_ENTRY:  inval_d = (mode_d == MODE_CLR) ? addr_d : shreg_d;
      ST_MID:    inval_d = (mode_d == MODE_RD) ? addr_d : shreg_d;
      default:   inval_d = (mode_d == MODE_RD) ? rdata_d : wdata_d;
    endcase
  end

  assign mem.mem_req   = req_q;
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;
  assign modeSelect    = mode_q;
  assign stage         = stage_q;
  assign inVal         = inval_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_mem_entry_ctrl.sv
// Directed bench: a 16-bit-address instance for read/write/back/reset cases
// and a 4-bit-address instance for the full clear sweep.
module tb_mem_entry_ctrl;

  logic        clk;
  logic        rst;
  logic [9:0]  sw, sw4;
  logic        btn_enter, btn_back, en4, bk4;
  logic [1:0]  mode16, stage16, mode4, stage4;
  logic [15:0] inval16, inval4;
  logic        busy16, busy4;

  int unsigned checks = 0;
  int unsigned errors = 0;

  mem_entry_ctrl_if m16 ();
  mem_entry_ctrl_if m4 ();

  mem_entry_ctrl #(.ADDR_W(16)) u_dut16 (
    .clk(clk), .rst(rst), .sw(sw), .btn_enter(btn_enter), .btn_back(btn_back),
    .mem(m16.master), .modeSelect(mode16), .stage(stage16), .inVal(inval16), .busy(busy16)
  );

  mem_entry_ctrl #(.ADDR_W(4)) u_dut4 (
    .clk(clk), .rst(rst), .sw(sw4), .btn_enter(en4), .btn_back(bk4),
    .mem(m4.master), .modeSelect(mode4), .stage(stage4), .inVal(inval4), .busy(busy4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One-cycle button pulse on the 16-bit instance; returns at the sampling edge.
  task automatic press(input logic [9:0] s, input logic e, input logic b);
    @(negedge clk);
    sw = s; btn_enter = e; btn_back = b;
    @(negedge clk);
    btn_enter = 1'b0; btn_back = 1'b0;
  endtask

  task automatic press4(input logic [9:0] s, input logic e);
    @(negedge clk);
    sw4 = s; en4 = e;
    @(negedge clk);
    en4 = 1'b0;
  endtask

  initial begin
    rst = 1'b1; sw = 10'h300; sw4 = 10'h300;
    btn_enter = 1'b1; btn_back = 1'b0; en4 = 1'b0; bk4 = 1'b0;
    m16.mem_ack = 1'b0; m16.mem_rdata = 16'h0000;
    m4.mem_ack = 1'b0;  m4.mem_rdata = 16'h0000;

    // Reset held two cycles with enter held high
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mode", 16'(mode16), 16'h3);
    chk("rst_stage", 16'(stage16), 16'h0);
    chk("rst_inval", inval16, 16'h0);
    chk("rst_req", 16'(m16.mem_req), 16'h0);
    chk("rst_we", 16'(m16.mem_we), 16'h0);
    chk("rst_addr", m16.mem_addr, 16'h0);
    chk("rst_wdata", m16.mem_wdata, 16'h0);
    chk("rst_busy", 16'(busy16), 16'h0);
    sw = 10'h100;
    @(negedge clk);
    chk("held_enter_no_press", 16'(stage16), 16'h0);
    chk("mode_follows_sw", 16'(mode16), 16'h1);
    btn_enter = 1'b0;

    // Read 0x1234, ack after three cycles with 0xBEEF
    press(10'h100, 1'b1, 1'b0);
    chk("rd_stage1", 16'(stage16), 16'h1);
    press(10'h101, 1'b1, 1'b0);
    press(10'h102, 1'b1, 1'b0);
    chk("rd_shreg2", inval16, 16'h0012);
    press(10'h303, 1'b1, 1'b0);
    chk("rd_mode_locked", 16'(mode16), 16'h1);
    press(10'h104, 1'b1, 1'b0);
    chk("rd_stage2", 16'(stage16), 16'h2);
    chk("rd_req", 16'(m16.mem_req), 16'h1);
    chk("rd_we", 16'(m16.mem_we), 16'h0);
    chk("rd_addr", m16.mem_addr, 16'h1234);
    chk("rd_inval_addr", inval16, 16'h1234);
    chk("rd_busy", 16'(busy16), 16'h1);
    repeat (2) @(negedge clk);
    chk("rd_hold_req", 16'(m16.mem_req), 16'h1);
    chk("rd_hold_addr", m16.mem_addr, 16'h1234);
    m16.mem_ack = 1'b1; m16.mem_rdata = 16'hBEEF;
    @(negedge clk);
    m16.mem_ack = 1'b0; m16.mem_rdata = 16'h0000;
    chk("rd_stage3", 16'(stage16), 16'h3);
    chk("rd_data", inval16, 16'hBEEF);
    chk("rd_req_drop", 16'(m16.mem_req), 16'h0);
    press(10'h100, 1'b1, 1'b0);
    chk("rd_exit_stage", 16'(stage16), 16'h0);
    chk("rd_exit_inval", inval16, 16'h0);

    // Write 0xCAFE to 0x00A5 with ack tied high
    press(10'h200, 1'b1, 1'b0);
    chk("wr_stage1", 16'(stage16), 16'h1);
    chk("wr_mode", 16'(mode16), 16'h2);
    press(10'h200, 1'b1, 1'b0);
    press(10'h200, 1'b1, 1'b0);
    press(10'h20A, 1'b1, 1'b0);
    press(10'h205, 1'b1, 1'b0);
    chk("wr_stage2", 16'(stage16), 16'h2);
    chk("wr_no_req_yet", 16'(m16.mem_req), 16'h0);
    m16.mem_ack = 1'b1;
    press(10'h20C, 1'b1, 1'b0);
    press(10'h20A, 1'b1, 1'b0);
    press(10'h20F, 1'b1, 1'b0);
    chk("wr_shreg3", inval16, 16'h0CAF);
    press(10'h20E, 1'b1, 1'b0);
    chk("wr_req", 16'(m16.mem_req), 16'h1);
    chk("wr_we", 16'(m16.mem_we), 16'h1);
    chk("wr_addr", m16.mem_addr, 16'h00A5);
    chk("wr_wdata", m16.mem_wdata, 16'hCAFE);
    chk("wr_stage3", 16'(stage16), 16'h3);
    @(negedge clk);
    chk("wr_req_one_cycle", 16'(m16.mem_req), 16'h0);
    chk("wr_busy_clr", 16'(busy16), 16'h0);
    chk("wr_stage_hold", 16'(stage16), 16'h3);
    chk("wr_inval", inval16, 16'hCAFE);
    m16.mem_ack = 1'b0;
    press(10'h200, 1'b1, 1'b0);
    chk("wr_exit", 16'(stage16), 16'h0);

    // Back after two nibbles
    press(10'h100, 1'b1, 1'b0);
    press(10'h105, 1'b1, 1'b0);
    press(10'h106, 1'b1, 1'b0);
    chk("bk_shreg", inval16, 16'h0056);
    press(10'h100, 1'b0, 1'b1);
    chk("bk_stage", 16'(stage16), 16'h0);
    chk("bk_inval", inval16, 16'h0);

    // Enter and back together: back wins
    press(10'h100, 1'b1, 1'b0);
    press(10'h107, 1'b1, 1'b0);
    chk("both_pre", inval16, 16'h0007);
    press(10'h107, 1'b1, 1'b1);
    chk("both_stage", 16'(stage16), 16'h0);
    chk("both_inval", inval16, 16'h0);

    // Back while a write is pending is ignored
    press(10'h200, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) press(10'h201, 1'b1, 1'b0);
    chk("bb_busy", 16'(busy16), 16'h1);
    chk("bb_wdata", m16.mem_wdata, 16'h1111);
    press(10'h200, 1'b0, 1'b1);
    chk("bb_stage", 16'(stage16), 16'h3);
    chk("bb_still_busy", 16'(busy16), 16'h1);
    m16.mem_ack = 1'b1;
    @(negedge clk);
    m16.mem_ack = 1'b0;
    chk("bb_done_req", 16'(m16.mem_req), 16'h0);
    chk("bb_done_stage", 16'(stage16), 16'h3);
    press(10'h200, 1'b1, 1'b0);
    chk("bb_exit", 16'(stage16), 16'h0);

    // Reset during a pending read
    press(10'h100, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) press(10'h109, 1'b1, 1'b0);
    chk("rr_req", 16'(m16.mem_req), 16'h1);
    rst = 1'b1;
    @(negedge clk);
    chk("rr_req_drop", 16'(m16.mem_req), 16'h0);
    chk("rr_stage", 16'(stage16), 16'h0);
    rst = 1'b0;

    // Full clear with ADDR_W=4 and ack tied high
    m4.mem_ack = 1'b1;
    press4(10'h000, 1'b1);
    chk("clr_stage", 16'(stage4), 16'h1);
    chk("clr_we", 16'(m4.mem_we), 16'h1);
    for (int i = 0; i < 16; i++) begin
      if (i != 0) @(negedge clk);
      chk($sformatf("clr_req%0d", i), 16'(m4.mem_req), 16'h1);
      chk($sformatf("clr_addr%0d", i), m4.mem_addr, 16'(i));
      chk($sformatf("clr_wdata%0d", i), m4.mem_wdata, 16'h0);
    end
    chk("clr_inval", inval4, 16'h000F);
    @(negedge clk);
    chk("clr_end_req", 16'(m4.mem_req), 16'h0);
    chk("clr_end_stage", 16'(stage4), 16'h0);

    // Idle mode ignores enter
    press4(10'h300, 1'b1);
    chk("idle_stage", 16'(stage4), 16'h0);
    chk("idle_req", 16'(m4.mem_req), 16'h0);
    m4.mem_ack = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_entry_ctrl.md
# mem_entry_ctrl

Front-panel input controller for the memory-control design. It turns switch nibbles and enter/back button presses into addresses and data, and runs read, write and whole-memory clear transactions over a req/ack memory port. It also produces the `stage`, `modeSelect` and `inVal` values consumed by the hex display block, making it the producer side of that display interface.

## Interface
Parameters:
- `ADDR_W`, default 16: implemented address bits, 1..16. Entered addresses are truncated to `ADDR_W`. Upper `mem_addr` bits are driven 0.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `sw` in 10: `sw[9:8]` selects the mode (00 clear, 01 read, 10 write, 11 idle). `sw[3:0]` is the entry nibble. Input is already synchronized.
- `btn_enter` in 1: level input, active-high, debounced upstream.
- `btn_back` in 1: level input, active-high, debounced upstream.
- `mem_ack` in 1: memory accepts or completes the current request.
- `mem_rdata` in 16: read data, valid while `mem_ack` is high.
- `mem_req` out 1: request valid.
- `mem_we` out 1: 1 = write, 0 = read.
- `mem_addr` out 16: request address.
- `mem_wdata` out 16: write data.
- `modeSelect` out 2: latched mode, goes to the display.
- `stage` out 2: current stage, goes to the display.
- `inVal` out 16: value shown on the display.
- `busy` out 1: high while a request is outstanding.

## Operation
- **Press detection**
  - Each button is registered into a `_q` flop; a press is `btn & ~btn_q`.
  - `_q` flops reset to 1, so a button held through reset yields no press.
  - If enter and back are pressed in the same cycle, back wins.
- **Mode latch**
  - `modeSelect` loads from `sw[9:8]` every cycle while `stage==0` and no request is outstanding.
  - In any other stage, switch changes are ignored.
- **Nibble entry**
  - Each enter press loads `shreg <= {shreg[11:0], sw[3:0]}` and increments a 2-bit digit counter.
  - The 4th press, when the counter wraps 3 to 0, completes the field and advances the stage.
  - The counter and `shreg` clear on every stage entry.
- **Read mode (01)**
  - Stage 0, banner: enter goes to stage 1.
  - Stage 1, address entry: after 4 nibbles, latch the address, drive `mem_req=1`, `mem_we=0`, go to stage 2.
  - Stage 2, pending: on ack, capture `mem_rdata`, drop the request, go to stage 3.
  - Stage 3, show data: enter goes to stage 0.
- **Write mode (10)**
  - Stage 0, banner: enter goes to stage 1.
  - Stage 1, address entry: after 4 nibbles, latch the address, go to stage 2.
  - Stage 2, data entry: after 4 nibbles, latch the data, drive `mem_req=1`, `mem_we=1`, go to stage 3.
  - Stage 3, pending: `busy=1` until ack. After ack the stage stays at 3 with `busy=0`. Enter when not busy goes to stage 0.
- **Clear mode (00)**
  - Stage 0: enter goes to stage 1 and starts writes with `mem_addr=0`, `mem_wdata=0`, `mem_req=1`, `mem_we=1`.
  - On each ack, the address increments. After the ack for address `2^ADDR_W-1`, `mem_req` drops and the stage returns to 0.
- **Idle mode (11)**: enter is ignored; stage stays 0.
- **Back**
  - In any entry stage (read 1, write 1/2) or in read/write stage 3 with no request outstanding: return to stage 0 and clear `shreg`.
  - Ignored while `busy` or while clearing.
- **`inVal` source by stage**
  - Entry stages: `shreg`.
  - Read stage 2: the address. Read stage 3: the captured read data.
  - Write stage 3: the write data.
  - Clear stage 1: the current address.
  - Stage 0: 0.
- **Reset values**: `modeSelect=2'b11`, `stage=0`, `inVal=0`, `mem_req=0`, `mem_we=0`, `mem_addr=0`, `mem_wdata=0`, `busy=0`, `shreg=0`, counter 0.

## Timing
- **Press latency**: an enter or back press updates state and outputs at the first `clk` edge where `btn==1 && btn_q==0`. The change is visible one cycle after the button rises.
- **Request registers**: `mem_req`, `mem_we`, `mem_addr` and `mem_wdata` are registered. `mem_req` rises on the same edge that enters the pending stage.
- **Stability**: request fields are held stable while `mem_req=1 && mem_ack=0`.
- **Completion**: a request completes at the edge where `mem_req && mem_ack`.
  - Read/write: `mem_req` is low from the next cycle.
  - Zero-wait ack (ack already high) gives a one-cycle request.
- **Ack outside a request**: `mem_ack` with `mem_req=0` is ignored.
- **Clear throughput**: `mem_req` stays high across acks. With ack held high, a full clear takes exactly `2^ADDR_W` cycles, one write per cycle.
- **Reset**: `rst` asserted mid-request drops `mem_req` at the next edge. No completion is recorded.

## Test plan
- **Reset**: hold `rst` 2 cycles with `btn_enter=1`, then release -> all outputs at reset values, `modeSelect=11`, no press detected until enter is released and pressed again.
- **Read** (`ADDR_W=16`, `sw[9:8]=01`): enter; nibbles 1,2,3,4 -> `stage=2`, `mem_req=1`, `mem_we=0`, `mem_addr=0x1234`. Ack after 3 cycles with `rdata=0xBEEF` -> `stage=3`, `inVal=0xBEEF`, `mem_req=0` next cycle. Enter -> `stage=0`.
- **Write**: address 0x00A5, data 0xCAFE, ack tied high -> exactly one cycle of `mem_req=1` with `we=1`, `addr=0x00A5`, `wdata=0xCAFE`; `stage=3`, `busy=0`, `inVal=0xCAFE`.
- **Clear** (`ADDR_W=4`, ack tied high): enter -> 16 consecutive write cycles, addresses 0..15, `wdata=0`; then `mem_req=0`, `stage=0`.
- **Back handling**
  - Back after 2 nibbles -> `stage=0`, `inVal=0`.
  - Enter and back in the same cycle -> back wins.
  - Back while `busy` -> ignored; request still completes.
- **Mode and reset corners**
  - Change `sw[9:8]` during `stage=1` -> `modeSelect` unchanged.
  - Assert `rst` during a pending read -> `mem_req=0` at the next edge, `stage=0`.
